// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 integer datapath.
// Define CTRL_PERF_CNT_EN to build the cycle/instret performance counters.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             irwrite,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pcen,
  output logic             memtoreg,
  output logic             brtaken,
  output logic             alusrcimm,
  output logic             writesreg,
  output logic             jump,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_wait;
  logic [15:0] w_waitNext;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_isBranch;
  logic        w_legal;
  logic        w_unused;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_isBranch = (w_opcode == OP_BRANCH) && (w_funct3 == 3'b000 || w_funct3 == 3'b001);
  assign w_legal    = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE) || (w_opcode == OP_OP) ||
                      (w_opcode == OP_OPIMM) || (w_opcode == OP_JAL) || w_isBranch;
  assign w_unused   = ^{instr[31:15], instr[11:7]};

  always_comb begin
    w_next    = r_state;
    imem_req  = 1'b0;
    irwrite   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pcen      = 1'b0;
    memtoreg  = 1'b0;
    brtaken   = 1'b0;
    alusrcimm = 1'b0;
    writesreg = 1'b0;
    jump      = 1'b0;
    trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          irwrite = 1'b1;
          w_next  = S_DECODE;
        end else if (r_wait == TIMEOUT_W) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_opcode)
          OP_OP: begin
            writesreg = 1'b1;
            pcen      = 1'b1;
          end
          OP_OPIMM: begin
            writesreg = 1'b1;
            alusrcimm = 1'b1;
            pcen      = 1'b1;
          end
          OP_BRANCH: begin
            brtaken = (w_funct3 == 3'b000) ? zero : ~zero;
            pcen    = 1'b1;
          end
          OP_JAL: begin
            jump = 1'b1;
            pcen = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            alusrcimm = 1'b1;
            w_next    = S_MEM;
          end
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        alusrcimm = 1'b1;
        dmem_we   = (w_opcode == OP_STORE);
        // A ready arriving on the timeout cycle still completes the access.
        if (dmem_ready) begin
          if (w_opcode == OP_STORE) begin
            pcen   = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (r_wait == TIMEOUT_W) begin
          w_next = S_TRAP;
        end
      end
      S_WB: begin
        memtoreg  = 1'b1;
        writesreg = 1'b1;
        alusrcimm = 1'b1;
        pcen      = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_waitNext = r_wait;
    if ((w_next != r_state) && (w_next == S_FETCH || w_next == S_MEM)) begin
      w_waitNext = 16'd0;
    end else if ((r_state == S_FETCH && !imem_ready) || (r_state == S_MEM && !dmem_ready)) begin
      w_waitNext = r_wait + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= 16'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_waitNext;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycleCnt;
  logic [CNT_W-1:0] r_instretCnt;

  // Retirement is exactly a pcen cycle, so TRAP naturally freezes instret.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycleCnt   <= '0;
      r_instretCnt <= '0;
    end else begin
      r_cycleCnt <= r_cycleCnt + CNT_W'(1);
      if (pcen) begin
        r_instretCnt <= r_instretCnt + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = r_cycleCnt;
  assign instret_cnt = r_instretCnt;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; expected strobe vectors are
// queued as each step is driven and popped when the DUT cycle is sampled.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [10:0] B_IMEM = 11'h400;
  localparam logic [10:0] B_IRW  = 11'h200;
  localparam logic [10:0] B_DREQ = 11'h100;
  localparam logic [10:0] B_DWE  = 11'h080;
  localparam logic [10:0] B_PCEN = 11'h040;
  localparam logic [10:0] B_M2R  = 11'h020;
  localparam logic [10:0] B_BR   = 11'h010;
  localparam logic [10:0] B_ASI  = 11'h008;
  localparam logic [10:0] B_WR   = 11'h004;
  localparam logic [10:0] B_JMP  = 11'h002;
  localparam logic [10:0] B_TRAP = 11'h001;
  localparam logic [10:0] NONE   = 11'h000;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_BEQ   = 32'h00000463;
  localparam logic [31:0] I_BNE   = 32'h00001463;
  localparam logic [31:0] I_BBAD  = 32'h00002463;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_ILLEG = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, irwrite, dmem_req, dmem_we, pcen, memtoreg;
  logic        brtaken, alusrcimm, writesreg, jump, trap;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [10:0] actVec;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] expQ[$];
  logic [31:0] expCycle;
  logic [31:0] expInstret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .irwrite(irwrite), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pcen(pcen), .memtoreg(memtoreg), .brtaken(brtaken), .alusrcimm(alusrcimm),
    .writesreg(writesreg), .jump(jump), .trap(trap),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  assign actVec = {imem_req, irwrite, dmem_req, dmem_we, pcen, memtoreg,
                   brtaken, alusrcimm, writesreg, jump, trap};

  // Counters only exist when the performance option is built in.
  function automatic logic [31:0] cntModel(input logic [31:0] v);
`ifdef CTRL_PERF_CNT_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic compare(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic z, input logic ir,
                               input logic dr, input logic [10:0] exp);
    instr      = ins;
    zero       = z;
    imem_ready = ir;
    dmem_ready = dr;
    expQ.push_back(exp);
  endtask

  // Samples on the falling edge, then advances to just after the next rising edge.
  task automatic checkOutput(input string tag);
    logic [10:0] e;
    @(negedge clk);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = expQ.pop_front();
      compare(tag, {21'd0, actVec}, {21'd0, e});
      compare({tag, "_cycle"}, cycle_cnt, cntModel(expCycle));
      compare({tag, "_instret"}, instret_cnt, cntModel(expInstret));
      if (e[6]) expInstret = expInstret + 32'd1;
    end
    expCycle = expCycle + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic z, input logic ir,
                      input logic dr, input logic [10:0] exp);
    applyStimulus(ins, z, ir, dr, exp);
    checkOutput(tag);
  endtask

  task automatic resetDut();
    reset      = 1'b1;
    instr      = 32'd0;
    zero       = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    expCycle   = 32'd0;
    expInstret = 32'd0;
  endtask

  initial begin
    resetDut();

    step("reset_fetch", I_ADDI, 1'b0, 1'b0, 1'b0, B_IMEM);
    step("addi_fetch",  I_ADDI, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("addi_decode", I_ADDI, 1'b0, 1'b0, 1'b1, NONE);
    step("addi_exec",   I_ADDI, 1'b0, 1'b0, 1'b0, B_PCEN | B_ASI | B_WR);

    step("lw_fetch",  I_LW, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("lw_decode", I_LW, 1'b0, 1'b1, 1'b1, NONE);
    step("lw_exec",   I_LW, 1'b0, 1'b0, 1'b1, B_ASI);
    for (int i = 0; i < 3; i++) step("lw_memwait", I_LW, 1'b0, 1'b1, 1'b0, B_DREQ | B_ASI);
    step("lw_memrdy", I_LW, 1'b0, 1'b0, 1'b1, B_DREQ | B_ASI);
    step("lw_wb",     I_LW, 1'b0, 1'b0, 1'b0, B_M2R | B_WR | B_ASI | B_PCEN);

    step("sw_fetch",  I_SW, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("sw_decode", I_SW, 1'b0, 1'b0, 1'b0, NONE);
    step("sw_exec",   I_SW, 1'b0, 1'b0, 1'b0, B_ASI);
    step("sw_mem",    I_SW, 1'b0, 1'b0, 1'b1, B_DREQ | B_DWE | B_ASI | B_PCEN);

    step("add_fetch",  I_ADD, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("add_decode", I_ADD, 1'b0, 1'b0, 1'b0, NONE);
    step("add_exec",   I_ADD, 1'b0, 1'b0, 1'b0, B_PCEN | B_WR);

    step("beq1_fetch", I_BEQ, 1'b1, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("beq1_dec",   I_BEQ, 1'b1, 1'b0, 1'b0, NONE);
    step("beq1_exec",  I_BEQ, 1'b1, 1'b0, 1'b0, B_BR | B_PCEN);
    step("bne1_fetch", I_BNE, 1'b1, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("bne1_dec",   I_BNE, 1'b1, 1'b0, 1'b0, NONE);
    step("bne1_exec",  I_BNE, 1'b1, 1'b0, 1'b0, B_PCEN);
    step("bne0_fetch", I_BNE, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("bne0_dec",   I_BNE, 1'b0, 1'b0, 1'b0, NONE);
    step("bne0_exec",  I_BNE, 1'b0, 1'b0, 1'b0, B_BR | B_PCEN);
    step("beq0_fetch", I_BEQ, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("beq0_dec",   I_BEQ, 1'b0, 1'b0, 1'b0, NONE);
    step("beq0_exec",  I_BEQ, 1'b0, 1'b0, 1'b0, B_PCEN);

    step("jal_fetch", I_JAL, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("jal_dec",   I_JAL, 1'b0, 1'b0, 1'b0, NONE);
    step("jal_exec",  I_JAL, 1'b0, 1'b0, 1'b0, B_JMP | B_PCEN);

    for (int i = 0; i < TO; i++) step("edge_fwait", I_ADDI, 1'b0, 1'b0, 1'b0, B_IMEM);
    step("edge_frdy",  I_ADDI, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("edge_dec",   I_ADDI, 1'b0, 1'b0, 1'b0, NONE);
    step("edge_exec",  I_ADDI, 1'b0, 1'b0, 1'b0, B_PCEN | B_ASI | B_WR);

    step("bbad_fetch", I_BBAD, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("bbad_dec",   I_BBAD, 1'b0, 1'b0, 1'b0, NONE);
    for (int i = 0; i < 3; i++) step("bbad_trap", I_BBAD, 1'b0, 1'b1, 1'b1, B_TRAP);

    resetDut();
    step("ill_fetch", I_ILLEG, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("ill_dec",   I_ILLEG, 1'b0, 1'b0, 1'b0, NONE);
    for (int i = 0; i < 10; i++) step("ill_trap", I_ILLEG, 1'b1, 1'b1, 1'b1, B_TRAP);

    resetDut();
    for (int i = 0; i <= TO; i++) step("tmo_fwait", I_ADDI, 1'b0, 1'b0, 1'b0, B_IMEM);
    step("tmo_trap",  I_ADDI, 1'b0, 1'b0, 1'b0, B_TRAP);
    step("tmo_hold",  I_ADDI, 1'b0, 1'b1, 1'b0, B_TRAP);

    resetDut();
    step("ar_fetch",   I_SW, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRW);
    step("ar_dec",     I_SW, 1'b0, 1'b0, 1'b0, NONE);
    step("ar_exec",    I_SW, 1'b0, 1'b0, 1'b0, B_ASI);
    step("ar_memwait", I_SW, 1'b0, 1'b0, 1'b0, B_DREQ | B_DWE | B_ASI);
    reset = 1'b1;
    #1;
    compare("ar_async_vec",     {21'd0, actVec}, {21'd0, B_IMEM});
    compare("ar_async_cycle",   cycle_cnt, 32'd0);
    compare("ar_async_instret", instret_cnt, 32'd0);
    dmem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      compare("ar_held_vec", {21'd0, actVec}, {21'd0, B_IMEM});
    end
    @(posedge clk);
    #1;
    reset      = 1'b0;
    expCycle   = 32'd0;
    expInstret = 32'd0;
    step("post_fetch", I_ADDI, 1'b0, 1'b1, 1'b1, B_IMEM | B_IRW);
    step("post_dec",   I_ADDI, 1'b0, 1'b0, 1'b0, NONE);
    step("post_exec",  I_ADDI, 1'b0, 1'b0, 1'b0, B_PCEN | B_ASI | B_WR);
    step("post_next",  I_ADDI, 1'b0, 1'b0, 1'b0, B_IMEM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
